// File: rtl/axis_audio_pkg.sv
// Shared audio-stream defaults and width helpers for the framer, broadcaster and FFT stages.
package axis_audio_pkg;

    localparam int unsigned AUDIO_DATA_WIDTH   = 32;
    localparam int unsigned AUDIO_SAMPLE_WIDTH = 24;
    localparam int unsigned AUDIO_FRAME_LEN    = 1024;
    localparam int unsigned DROP_COUNT_WIDTH   = 16;

    // Bits needed to index 'value' entries (ceil(log2(value))).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        int unsigned span;
        width = 0;
        span  = 1;
        while (span < value) begin
            span  = span << 1;
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; head entry is visible on head_data while not empty.
module sync_fifo_fwft
    import axis_audio_pkg::*;
#(
    parameter int unsigned WIDTH = AUDIO_SAMPLE_WIDTH,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned CNT_W = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            empty <= (count_next == CNT_W'(0));
            full  <= (count_next == CNT_W'(DEPTH));
        end
    end

    // Storage needs no reset; empty gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/axis_sample_framer.sv
// Buffers PCM samples into an AXI4-Stream with sign extension, TLAST framing and drop accounting.
module axis_sample_framer
    import axis_audio_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
    parameter int unsigned DATA_WIDTH   = AUDIO_DATA_WIDTH,
    parameter int unsigned FRAME_LEN    = AUDIO_FRAME_LEN,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                        AXIS_ACLK,
    input  logic                        AXIS_ARESET,
    input  logic [SAMPLE_WIDTH-1:0]     SAMPLE_DATA,
    input  logic                        SAMPLE_VALID,
    output logic [DATA_WIDTH-1:0]       M_AXIS_TDATA,
    output logic                        M_AXIS_TVALID,
    output logic                        M_AXIS_TLAST,
    input  logic                        M_AXIS_TREADY,
    output logic                        OVERFLOW,
    output logic [DROP_COUNT_WIDTH-1:0] DROP_COUNT,
    input  logic                        OVERFLOW_CLR
);

    localparam int unsigned BEAT_W = clog2(FRAME_LEN);
    localparam int unsigned CNT_W  = clog2(FIFO_DEPTH) + 1;
    localparam logic [BEAT_W-1:0]           LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
    localparam logic [DROP_COUNT_WIDTH-1:0] DROP_MAX  = '1;

    logic [SAMPLE_WIDTH-1:0]     head_sample;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [CNT_W-1:0]            fifo_count;
    logic                        fifo_count_unused;
    logic                        handshake;
    logic                        accept;
    logic                        push;
    logic                        drop;
    logic [BEAT_W-1:0]           beat_q;
    logic                        overflow_q;
    logic                        overflow_d;
    logic [DROP_COUNT_WIDTH-1:0] drop_count_q;
    logic [DROP_COUNT_WIDTH-1:0] drop_count_d;

    assign handshake = M_AXIS_TVALID && M_AXIS_TREADY;
    assign accept    = !fifo_full || handshake;
    assign push      = SAMPLE_VALID && accept;
    assign drop      = SAMPLE_VALID && !accept;

    // Occupancy is carried by full/empty here; the raw count is only for observability.
    assign fifo_count_unused = ^fifo_count;

    sync_fifo_fwft #(
        .WIDTH (SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (AXIS_ACLK),
        .rst       (AXIS_ARESET),
        .push      (push),
        .push_data (SAMPLE_DATA),
        .pop       (handshake),
        .head_data (head_sample),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Zero the data bus while idle so reset and empty present a clean TDATA.
    assign M_AXIS_TVALID = !fifo_empty;
    assign M_AXIS_TDATA  = M_AXIS_TVALID ? DATA_WIDTH'($signed(head_sample)) : '0;
    assign M_AXIS_TLAST  = M_AXIS_TVALID && (beat_q == LAST_BEAT);

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            beat_q <= '0;
        end else if (handshake) begin
            beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
        end
    end

    // Clear applies first so that a same-cycle drop restarts the count at one.
    always_comb begin
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (OVERFLOW_CLR) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_d != DROP_MAX) begin
                drop_count_d = drop_count_d + DROP_COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign OVERFLOW   = overflow_q;
    assign DROP_COUNT = drop_count_q;

endmodule

// File: tb/tb_axis_sample_framer.sv
// Randomised and directed bench for axis_sample_framer against a queue-based reference model.
module tb_axis_sample_framer;

    localparam int unsigned SW    = 24;
    localparam int unsigned DW    = 32;
    localparam int unsigned FLEN  = 4;
    localparam int unsigned DEPTH = 4;

    logic          clk;
    logic          rst;
    logic [SW-1:0] sample_data;
    logic          sample_valid;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;
    logic          overflow;
    logic [15:0]   drop_count;
    logic          overflow_clr;

    axis_sample_framer #(
        .SAMPLE_WIDTH (SW),
        .DATA_WIDTH   (DW),
        .FRAME_LEN    (FLEN),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .AXIS_ACLK     (clk),
        .AXIS_ARESET   (rst),
        .SAMPLE_DATA   (sample_data),
        .SAMPLE_VALID  (sample_valid),
        .M_AXIS_TDATA  (tdata),
        .M_AXIS_TVALID (tvalid),
        .M_AXIS_TLAST  (tlast),
        .M_AXIS_TREADY (tready),
        .OVERFLOW      (overflow),
        .DROP_COUNT    (drop_count),
        .OVERFLOW_CLR  (overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: buffered samples, output beat index, status.
    logic [SW-1:0] mq[$];
    int            m_beat = 0;
    bit            m_ovf  = 0;
    int            m_drops = 0;

    // Observed handshake numbering since the last reset, and where TLAST was seen.
    int hs_idx = 0;
    int last_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [SW-1:0] s);
        int v;
        v = int'(s);
        if (s[SW-1]) v = v - (1 << SW);
        return 32'(v);
    endfunction

    // One clock: drive inputs, compare outputs mid-cycle, advance the model across the edge.
    task automatic step(input logic r, input logic v, input logic [SW-1:0] d,
                        input logic rdy, input logic clr, input bit chk);
        bit exp_valid;
        bit pop;
        bit acc;
        rst          = r;
        sample_valid = v;
        sample_data  = d;
        tready       = rdy;
        overflow_clr = clr;
        @(negedge clk);
        exp_valid = (mq.size() != 0);
        if (chk) begin
            check("tvalid", 32'(tvalid), 32'(exp_valid));
            check("tdata", tdata, exp_valid ? sext(mq[0]) : 32'd0);
            check("tlast", 32'(tlast), 32'(exp_valid && (m_beat == FLEN - 1)));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("drop_count", 32'(drop_count), 32'(m_drops));
        end
        if (r) begin
            mq.delete();
            m_beat  = 0;
            m_ovf   = 0;
            m_drops = 0;
            hs_idx  = 0;
            last_q.delete();
        end else begin
            if (tvalid && rdy) begin
                if (tlast) last_q.push_back(hs_idx);
                hs_idx++;
            end
            pop = exp_valid && rdy;
            acc = (mq.size() < DEPTH) || pop;
            if (pop) begin
                void'(mq.pop_front());
                m_beat = (m_beat + 1) % FLEN;
            end
            if (clr) begin
                m_ovf   = 0;
                m_drops = 0;
            end
            if (v) begin
                if (acc) mq.push_back(d);
                else begin
                    m_ovf = 1;
                    if (m_drops != 16'hFFFF) m_drops++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, rdy, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_data  = '0;
        tready       = 1'b0;
        overflow_clr = 1'b0;
        @(posedge clk);
        #1;

        // Reset and first beat
        do_reset(3);
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tdata", tdata, 32'd0);
        step(1'b0, 1'b1, 24'h800001, 1'b1, 1'b0, 1'b1);
        check("first_tvalid", 32'(tvalid), 32'd1);
        check("first_tdata", tdata, 32'hFF800001);
        check("first_tlast", 32'(tlast), 32'd0);
        idle(2, 1'b1);

        // Framing: 10 back-to-back samples, then 2 more
        do_reset(1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, SW'(24'h100 + i), 1'b1, 1'b0, 1'b1);
        idle(1, 1'b1);
        check("frame_last_count", 32'(last_q.size()), 32'd2);
        if (last_q.size() >= 2) begin
            check("frame_last0", 32'(last_q[0]), 32'd3);
            check("frame_last1", 32'(last_q[1]), 32'd7);
        end
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, SW'(24'hF00000 + i), 1'b1, 1'b0, 1'b1);
        idle(1, 1'b1);
        check("frame_last_count2", 32'(last_q.size()), 32'd3);
        if (last_q.size() >= 3) check("frame_last2", 32'(last_q[2]), 32'd11);

        // Overflow with TREADY low, then full plus simultaneous pop
        do_reset(1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, SW'(24'h000010 + i), 1'b0, 1'b0, 1'b1);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_drops", 32'(drop_count), 32'd2);
        step(1'b0, 1'b1, 24'h0000AA, 1'b1, 1'b0, 1'b1);
        check("full_pop_drops", 32'(drop_count), 32'd2);
        check("full_pop_head", tdata, 32'h00000011);
        idle(6, 1'b1);

        // Clear versus drop, then saturation
        do_reset(1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, SW'($urandom), 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, SW'($urandom), 1'b0, 1'b1, 1'b1);
        check("clr_drop_flag", 32'(overflow), 32'd1);
        check("clr_drop_count", 32'(drop_count), 32'd1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        check("clr_flag", 32'(overflow), 32'd0);
        check("clr_count", 32'(drop_count), 32'd0);
        for (int i = 0; i < 65540; i++) step(1'b0, 1'b1, SW'($urandom), 1'b0, 1'b0, 1'b0);
        check("sat_count", 32'(drop_count), 32'h0000FFFF);
        step(1'b0, 1'b1, SW'($urandom), 1'b0, 1'b0, 1'b1);
        check("sat_hold", 32'(drop_count), 32'h0000FFFF);
        idle(6, 1'b1);

        // Reset mid-frame
        do_reset(1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, SW'(24'h300 + i), 1'b1, 1'b0, 1'b1);
        idle(1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, SW'(24'h400 + i), 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("midrst_tvalid", 32'(tvalid), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, SW'(24'h500 + i), 1'b1, 1'b0, 1'b1);
        idle(1, 1'b1);
        check("midrst_last_count", 32'(last_q.size()), 32'd1);
        if (last_q.size() >= 1) check("midrst_last0", 32'(last_q[0]), 32'd3);

        // Randomised traffic with occasional clears and resets
        for (int i = 0; i < 3000; i++) begin
            step(1'b0 || ($urandom_range(0, 199) == 0),
                 $urandom_range(0, 9) < 6,
                 SW'($urandom),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 49) == 0,
                 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
